// File: rtl/wb_pkg.sv
// Shared types for the L1->L2 write buffer: drain states, entry layout
// and the byte-merge helper used when coalescing stores.
package wb_pkg;

  localparam int WB_ADDR_W  = 32;
  localparam int WB_DATA_W  = 32;
  localparam int WB_BE_W    = WB_DATA_W / 8;
  localparam int WB_WADDR_W = WB_ADDR_W - 2;
  localparam int WB_DEPTH   = 4;

  typedef enum logic [0:0] {
    WB_IDLE  = 1'b0,
    WB_DRAIN = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [WB_WADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
    logic [WB_BE_W-1:0]    mask;
    logic                  valid;
  } wb_entry_t;

  function automatic logic [WB_DATA_W-1:0] wb_merge(
    input logic [WB_DATA_W-1:0] old_d,
    input logic [WB_DATA_W-1:0] new_d,
    input logic [WB_BE_W-1:0]   be
  );
    logic [WB_DATA_W-1:0] res;
    res = old_d;
    for (int b = 0; b < WB_BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_d[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_cam.sv
// Word-address CAM: walks entries oldest-to-youngest from head so the
// last match seen is the youngest one.
module wb_cam
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  parameter  int AW    = WB_WADDR_W,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] addr_i,
  input  logic [DEPTH-1:0]         vld_i,
  input  logic [PW-1:0]            head_i,
  input  logic [AW-1:0]            key_i,
  output logic                     hit_o,
  output logic [PW-1:0]            idx_o
);

  logic [DEPTH-1:0] match;
  logic [PW-1:0]    slot;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = vld_i[i] & (addr_i[i] == key_i);
    end
  end

  always_comb begin
    hit_o = 1'b0;
    idx_o = head_i;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_i + PW'(k);
      if (match[slot]) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/l1_l2_write_buffer.sv
// Coalescing write-back buffer between L1 and L2 with store-to-load
// forwarding and an in-order drain over a valid/ack handshake.
module l1_l2_write_buffer
  import wb_pkg::*;
#(
  parameter  int ADDR_W = WB_ADDR_W,
  parameter  int DATA_W = WB_DATA_W,
  parameter  int DEPTH  = WB_DEPTH,
  localparam int BE_W   = DATA_W / 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_valid,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [BE_W-1:0]   wr_req_be,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] rd_lookup_addr,
  output logic              rd_hit,
  output logic              rd_partial,
  output logic [DATA_W-1:0] rd_hit_data,
  output logic              l2_wr_valid,
  output logic [ADDR_W-1:0] l2_wr_addr,
  output logic [DATA_W-1:0] l2_wr_data,
  output logic [BE_W-1:0]   l2_wr_be,
  input  logic              l2_wr_ack,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;
  wb_state_e             state_q;
  logic                  l2_valid_q;
  logic [ADDR_W-1:0]     l2_addr_q;
  logic [DATA_W-1:0]     l2_data_q;
  logic [BE_W-1:0]       l2_be_q;

  logic [DEPTH-1:0][WB_WADDR_W-1:0] cam_addr;
  logic [DEPTH-1:0]      cam_vld, lock_vec;
  logic                  co_hit, fw_hit;
  logic [PTR_W-1:0]      co_idx, fw_idx;
  logic                  push, alloc, pop;
  wb_entry_t             fw_ent;
  logic                  unused_lsb;

  assign unused_lsb = ^{wr_req_addr[1:0], rd_lookup_addr[1:0]};

  always_comb begin
    lock_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cam_addr[i] = ent_q[i].addr;
      cam_vld[i]  = ent_q[i].valid;
    end
    lock_vec[head_q] = (state_q == WB_DRAIN);
  end

  wb_cam #(.DEPTH(DEPTH), .AW(WB_WADDR_W)) u_coal (
    .addr_i (cam_addr),
    .vld_i  (cam_vld & ~lock_vec),
    .head_i (head_q),
    .key_i  (wr_req_addr[ADDR_W-1:2]),
    .hit_o  (co_hit),
    .idx_o  (co_idx)
  );

  wb_cam #(.DEPTH(DEPTH), .AW(WB_WADDR_W)) u_fwd (
    .addr_i (cam_addr),
    .vld_i  (cam_vld),
    .head_i (head_q),
    .key_i  (rd_lookup_addr[ADDR_W-1:2]),
    .hit_o  (fw_hit),
    .idx_o  (fw_idx)
  );

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign wr_req_ready = ~flush_req & (~full | co_hit);
  assign push         = wr_req_valid & wr_req_ready;
  assign alloc        = push & ~co_hit;
  assign pop          = (state_q == WB_DRAIN) & l2_wr_ack;
  assign count_d      = count_q + CNT_W'(alloc) - CNT_W'(pop);

  always_comb begin
    ent_d = ent_q;
    if (pop) ent_d[head_q].valid = 1'b0;
    if (push) begin
      if (co_hit) begin
        ent_d[co_idx].data = wb_merge(ent_q[co_idx].data, wr_req_data, wr_req_be);
        ent_d[co_idx].mask = ent_q[co_idx].mask | wr_req_be;
      end else begin
        ent_d[tail_q].addr  = wr_req_addr[ADDR_W-1:2];
        ent_d[tail_q].data  = wb_merge('0, wr_req_data, wr_req_be);
        ent_d[tail_q].mask  = wr_req_be;
        ent_d[tail_q].valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_q + PTR_W'(pop);
      tail_q  <= tail_q + PTR_W'(alloc);
      count_q <= count_d;
    end
  end

  // Launch from ent_d so a store coalesced into the head on the
  // launch edge still reaches L2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WB_IDLE;
      l2_valid_q <= 1'b0;
      l2_addr_q  <= '0;
      l2_data_q  <= '0;
      l2_be_q    <= '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (count_q != '0) begin
            state_q    <= WB_DRAIN;
            l2_valid_q <= 1'b1;
            l2_addr_q  <= {ent_d[head_q].addr, 2'b00};
            l2_data_q  <= ent_d[head_q].data;
            l2_be_q    <= ent_d[head_q].mask;
          end
        end
        WB_DRAIN: begin
          if (l2_wr_ack) begin
            state_q    <= WB_IDLE;
            l2_valid_q <= 1'b0;
          end
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign fw_ent      = ent_q[fw_idx];
  assign rd_hit      = fw_hit & (&fw_ent.mask);
  assign rd_partial  = fw_hit & ~(&fw_ent.mask);
  assign rd_hit_data = fw_hit ? fw_ent.data : '0;

  assign l2_wr_valid = l2_valid_q;
  assign l2_wr_addr  = l2_addr_q;
  assign l2_wr_data  = l2_data_q;
  assign l2_wr_be    = l2_be_q;
  assign count       = count_q;
  assign flush_done  = flush_req & empty & (state_q == WB_IDLE);

endmodule

// File: tb/tb_l1_l2_write_buffer.sv
// Directed bench for l1_l2_write_buffer: coalescing, forwarding,
// full/ready gating, FIFO drain order, flush and async reset.
module tb_l1_l2_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req_valid;
  logic [31:0] wr_req_addr;
  logic [31:0] wr_req_data;
  logic [3:0]  wr_req_be;
  logic        wr_req_ready;
  logic [31:0] rd_lookup_addr;
  logic        rd_hit;
  logic        rd_partial;
  logic [31:0] rd_hit_data;
  logic        l2_wr_valid;
  logic [31:0] l2_wr_addr;
  logic [31:0] l2_wr_data;
  logic [3:0]  l2_wr_be;
  logic        l2_wr_ack;
  logic        flush_req;
  logic        flush_done;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_l2_write_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .wr_req_valid   (wr_req_valid),
    .wr_req_addr    (wr_req_addr),
    .wr_req_data    (wr_req_data),
    .wr_req_be      (wr_req_be),
    .wr_req_ready   (wr_req_ready),
    .rd_lookup_addr (rd_lookup_addr),
    .rd_hit         (rd_hit),
    .rd_partial     (rd_partial),
    .rd_hit_data    (rd_hit_data),
    .l2_wr_valid    (l2_wr_valid),
    .l2_wr_addr     (l2_wr_addr),
    .l2_wr_data     (l2_wr_data),
    .l2_wr_be       (l2_wr_be),
    .l2_wr_ack      (l2_wr_ack),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    wr_req_valid = 1'b1;
    wr_req_addr  = a;
    wr_req_data  = d;
    wr_req_be    = be;
    step();
    wr_req_valid = 1'b0;
  endtask

  task automatic drain_one(input string tag, input logic [31:0] a,
                           input logic [31:0] d);
    int n = 0;
    while (!l2_wr_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, l2_wr_valid, 1'b1);
    chk({tag, "_addr"}, l2_wr_addr, a);
    chk({tag, "_data"}, l2_wr_data, d);
    l2_wr_ack = 1'b1;
    step();
    l2_wr_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_req_valid = 1'b0;
    wr_req_addr = '0;
    wr_req_data = '0;
    wr_req_be = '0;
    rd_lookup_addr = '0;
    l2_wr_ack = 1'b0;
    flush_req = 1'b0;
    step();
    step();

    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_l2v", l2_wr_valid, 1'b0);
    chk("rst_l2a", l2_wr_addr, 32'h0);
    chk("rst_fd", flush_done, 1'b0);
    flush_req = 1'b1;
    #1;
    chk("rst_fd_flush", flush_done, 1'b1);
    flush_req = 1'b0;
    step();
    rst = 1'b0;
    step();

    // single write and drain
    wr(32'h100, 32'hDEADBEEF, 4'hF);
    chk("t1_count", count, 3'd1);
    chk("t1_l2v_early", l2_wr_valid, 1'b0);
    step();
    chk("t1_l2v", l2_wr_valid, 1'b1);
    chk("t1_l2a", l2_wr_addr, 32'h100);
    chk("t1_l2d", l2_wr_data, 32'hDEADBEEF);
    chk("t1_l2be", l2_wr_be, 4'hF);
    l2_wr_ack = 1'b1;
    step();
    l2_wr_ack = 1'b0;
    chk("t1_empty", empty, 1'b1);
    chk("t1_l2v_off", l2_wr_valid, 1'b0);

    // coalesce two half-words, second lands on the launch edge
    wr(32'h200, 32'h0000_1111, 4'h3);
    wr(32'h200, 32'h2222_0000, 4'hC);
    chk("t2_count", count, 3'd1);
    rd_lookup_addr = 32'h202;
    #1;
    chk("t2_hit", rd_hit, 1'b1);
    chk("t2_part", rd_partial, 1'b0);
    chk("t2_data", rd_hit_data, 32'h2222_1111);
    chk("t2_l2be", l2_wr_be, 4'hF);
    drain_one("t2_d", 32'h200, 32'h2222_1111);
    chk("t2_empty", empty, 1'b1);

    // fill, refuse fifth, ack frees a slot, FIFO drain order
    for (int i = 0; i < 4; i++) begin
      wr(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    end
    chk("t3_full", full, 1'b1);
    chk("t3_count", count, 3'd4);
    wr_req_valid = 1'b1;
    wr_req_addr = 32'h20;
    wr_req_data = 32'hA000_0004;
    wr_req_be = 4'hF;
    #1;
    chk("t3_rdy0", wr_req_ready, 1'b0);
    chk("t3_l2a0", l2_wr_addr, 32'h10);
    l2_wr_ack = 1'b1;
    step();
    l2_wr_ack = 1'b0;
    chk("t3_cnt3", count, 3'd3);
    chk("t3_rdy1", wr_req_ready, 1'b1);
    step();
    wr_req_valid = 1'b0;
    chk("t3_cnt4", count, 3'd4);
    for (int i = 1; i < 5; i++) begin
      drain_one($sformatf("t3_d%0d", i), 32'h10 + 32'(4 * i),
                32'hA000_0000 + 32'(i));
    end
    chk("t3_empty", empty, 1'b1);

    // write to the locked head allocates; lookup sees youngest
    wr(32'h300, 32'h0000_000A, 4'hF);
    step();
    chk("t4_l2a", l2_wr_addr, 32'h300);
    wr(32'h300, 32'h0000_0005, 4'hF);
    chk("t4_count", count, 3'd2);
    rd_lookup_addr = 32'h300;
    #1;
    chk("t4_hit", rd_hit, 1'b1);
    chk("t4_data", rd_hit_data, 32'h5);
    drain_one("t4_a", 32'h300, 32'hA);
    drain_one("t4_b", 32'h300, 32'h5);
    chk("t4_empty", empty, 1'b1);

    // partial forwarding, miss, then flush of three entries
    wr(32'h400, 32'h0000_0077, 4'h1);
    rd_lookup_addr = 32'h400;
    #1;
    chk("t5_part", rd_partial, 1'b1);
    chk("t5_hit", rd_hit, 1'b0);
    rd_lookup_addr = 32'h500;
    #1;
    chk("t5_miss_p", rd_partial, 1'b0);
    chk("t5_miss_d", rd_hit_data, 32'h0);
    wr(32'h404, 32'h0000_0404, 4'hF);
    wr(32'h408, 32'h0000_0408, 4'hF);
    chk("t5_count", count, 3'd3);
    flush_req = 1'b1;
    wr_req_valid = 1'b1;
    wr_req_addr = 32'h40C;
    wr_req_be = 4'hF;
    #1;
    chk("t5_rdy", wr_req_ready, 1'b0);
    chk("t5_fd0", flush_done, 1'b0);
    drain_one("t5_a", 32'h400, 32'h77);
    drain_one("t5_b", 32'h404, 32'h404);
    chk("t5_fd1", flush_done, 1'b0);
    drain_one("t5_c", 32'h408, 32'h408);
    chk("t5_fd", flush_done, 1'b1);
    chk("t5_cnt0", count, 3'd0);
    flush_req = 1'b0;
    wr_req_valid = 1'b0;
    step();

    // async reset mid-drain
    wr(32'h600, 32'h6, 4'hF);
    wr(32'h604, 32'h7, 4'hF);
    chk("t6_l2v", l2_wr_valid, 1'b1);
    chk("t6_cnt", count, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_l2v", l2_wr_valid, 1'b0);
    chk("t6_rst_cnt", count, 3'd0);
    chk("t6_rst_emp", empty, 1'b1);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
